// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port ram block and its clients: default widths,
// the burst reader state encoding and a small sizing helper.
package ram_pkg;

    localparam int RAM_D_WIDTH = 16;
    localparam int RAM_A_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Bits needed to hold a count from 0 up to and including depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ram_rd_fifo.sv
// Small synchronous FIFO for the burst reader. The head entry is presented from
// registered storage, and the occupancy count feeds the reader's credit logic.
module ram_rd_fifo
    import ram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17,
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    assign pop_valid = (count != '0);
    assign pop_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read client for the ram read port: walks addresses one per cycle, hides the
// one-cycle registered read latency and streams words out with full backpressure.
module ram_burst_reader
    import ram_pkg::*;
#(
    parameter int D_WIDTH    = RAM_D_WIDTH,
    parameter int A_WIDTH    = RAM_A_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [A_WIDTH-1:0] cmd_addr,
    input  logic [A_WIDTH:0]   cmd_len,
    output logic [A_WIDTH-1:0] address_read,
    input  logic [D_WIDTH-1:0] data_read,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = count_width(FIFO_DEPTH);
    localparam int OCC_W = CNT_W + 1;
    localparam logic [A_WIDTH:0]   LEN_ONE   = (A_WIDTH + 1)'(1);
    localparam logic [A_WIDTH-1:0] ADDR_ONE  = A_WIDTH'(1);
    localparam logic [OCC_W-1:0]   DEPTH_OCC = OCC_W'(FIFO_DEPTH);

    rd_state_t          state;
    logic [A_WIDTH:0]   issued;
    logic [A_WIDTH:0]   len_reg;
    logic [1:0]         inflight_v;
    logic [1:0]         inflight_last;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_valid;
    logic [D_WIDTH:0]   fifo_data;
    logic               handshake;
    logic [OCC_W-1:0]   occupancy;
    logic               can_issue;
    logic               issue_last;

    assign handshake = fifo_valid && out_ready;

    // Every buffered word and every read still in the ram pipeline holds a FIFO slot.
    assign occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight_v[0]) + OCC_W'(inflight_v[1]);
    assign can_issue  = (state == RUN) && (occupancy < (DEPTH_OCC + OCC_W'(handshake)));
    assign issue_last = ((issued + LEN_ONE) == len_reg);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = fifo_valid;
    assign out_data  = fifo_data[D_WIDTH-1:0];
    assign out_last  = fifo_data[D_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            address_read  <= '0;
            issued        <= '0;
            len_reg       <= '0;
            inflight_v    <= '0;
            inflight_last <= '0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight_v    <= {inflight_v[0], 1'b0};
            inflight_last <= {inflight_last[0], 1'b0};
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        len_reg <= cmd_len;
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            address_read     <= cmd_addr;
                            issued           <= LEN_ONE;
                            inflight_v[0]    <= 1'b1;
                            inflight_last[0] <= (cmd_len == LEN_ONE);
                            state            <= (cmd_len == LEN_ONE) ? DRAIN : RUN;
                        end
                    end
                end
                RUN: begin
                    if (can_issue) begin
                        address_read     <= address_read + ADDR_ONE;
                        issued           <= issued + LEN_ONE;
                        inflight_v[0]    <= 1'b1;
                        inflight_last[0] <= issue_last;
                        if (issue_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (handshake && out_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (D_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_v[1]),
        .push_data ({inflight_last[1], data_read}),
        .pop       (handshake),
        .pop_valid (fifo_valid),
        .pop_data  (fifo_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader: a behavioural ram model, a queue of expected
// words filled at command accept, and a monitor that checks every handshake and pulse.
module tb_ram_burst_reader;

    localparam int D_WIDTH    = 16;
    localparam int A_WIDTH    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int RAM_WORDS  = 16;

    logic               clk;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [A_WIDTH-1:0] cmd_addr;
    logic [A_WIDTH:0]   cmd_len;
    logic [A_WIDTH-1:0] address_read;
    logic [D_WIDTH-1:0] data_read;
    logic               out_valid;
    logic               out_ready;
    logic [D_WIDTH-1:0] out_data;
    logic               out_last;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_seen  = 0;
    int ready_mode = 0;
    int ready_phase = 0;

    logic [D_WIDTH-1:0] ram_mem [RAM_WORDS];
    logic [D_WIDTH:0]   exp_q [$];

    logic               prev_last_hs;
    logic               prev_len0;
    logic               exp_busy;
    logic               prev_stall;
    logic [D_WIDTH-1:0] prev_data;
    logic               prev_last;
    logic               mon_accept;
    logic               mon_hs;
    logic               mon_hs_last;
    logic [D_WIDTH:0]   mon_word;

    ram_burst_reader #(
        .D_WIDTH    (D_WIDTH),
        .A_WIDTH    (A_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .address_read (address_read),
        .data_read    (data_read),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ram read port: one registered cycle from address to data.
    always @(posedge clk) begin
        data_read <= ram_mem[address_read];
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_phase++;
            case (ready_mode)
                1:       out_ready = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
                2:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_reset_values();
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_data", 32'(out_data), 32'd0);
        check_output("rst_out_last", 32'(out_last), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_output("rst_address_read", 32'(address_read), 32'd0);
    endtask

    // Drives a command, waits for acceptance and records the words it must produce.
    task automatic apply_stimulus(input logic [A_WIDTH-1:0] addr, input logic [A_WIDTH:0] len,
                                  input bit expect_done);
        logic             got;
        logic [A_WIDTH-1:0] a;
        got       = 1'b0;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL cmd_accept_timeout: got no accept, expected accept within 400 cycles");
        end else begin
            if (expect_done) check_output("done_at_accept", 32'(done), 32'd1);
            for (int i = 0; i < int'(len); i++) begin
                a = addr + A_WIDTH'(i);
                exp_q.push_back({(i == int'(len) - 1), ram_mem[a]});
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic check_latency(input logic [A_WIDTH-1:0] addr);
        @(negedge clk);
        check_output("first_address", 32'(address_read), 32'(addr));
        check_output("latency_edge0", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_output("latency_edge1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_output("latency_edge2", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ((exp_q.size() == 0) && !busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL burst_timeout: %0d words outstanding, busy=%0b", exp_q.size(), busy);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: the expected done/busy behaviour is derived from accepted commands and
    // the scoreboard's own last-word markers, never from the DUT's state.
    always @(negedge clk) begin
        if (rst) begin
            prev_last_hs = 1'b0;
            prev_len0    = 1'b0;
            exp_busy     = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            check_output("done", 32'(done), 32'(prev_last_hs || prev_len0));
            check_output("busy", 32'(busy), 32'(exp_busy));
            check_output("cmd_ready", 32'(cmd_ready), 32'(!exp_busy));
            check_output("fifo_bound", 32'(int'(dut.u_fifo.count) <= FIFO_DEPTH), 32'd1);
            if (prev_stall) begin
                check_output("stall_valid", 32'(out_valid), 32'd1);
                check_output("stall_data", 32'(out_data), 32'(prev_data));
                check_output("stall_last", 32'(out_last), 32'(prev_last));
            end
            mon_accept  = cmd_valid && !exp_busy;
            mon_hs      = out_valid && out_ready;
            mon_hs_last = 1'b0;
            if (mon_hs) begin
                hs_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_word: got %0h, expected no output", out_data);
                end else begin
                    mon_word = exp_q.pop_front();
                    check_output("out_data", 32'(out_data), 32'(mon_word[D_WIDTH-1:0]));
                    check_output("out_last", 32'(out_last), 32'(mon_word[D_WIDTH]));
                    mon_hs_last = mon_word[D_WIDTH];
                end
            end
            prev_last_hs = mon_hs && mon_hs_last;
            prev_len0    = mon_accept && (cmd_len == '0);
            if (mon_accept && (cmd_len != '0)) exp_busy = 1'b1;
            else if (prev_last_hs) exp_busy = 1'b0;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        int target;
        int len_r;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        for (int i = 0; i < RAM_WORDS; i++) ram_mem[i] = 16'hA000 + 16'(i);
        @(negedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] full-depth burst");
        apply_stimulus(4'd0, 5'd16, 1'b0);
        check_latency(4'd0);
        wait_idle();

        $display("[TB] wrapping burst");
        apply_stimulus(4'd14, 5'd4, 1'b0);
        check_latency(4'd14);
        wait_idle();

        $display("[TB] backpressure 1,0,0,1");
        ready_mode = 1;
        apply_stimulus(4'd3, 5'd8, 1'b0);
        wait_idle();
        ready_mode = 0;

        $display("[TB] zero-length command");
        apply_stimulus(4'd7, 5'd0, 1'b0);
        @(negedge clk);
        check_output("len0_done", 32'(done), 32'd1);
        check_output("len0_cmd_ready", 32'(cmd_ready), 32'd1);
        check_output("len0_out_valid", 32'(out_valid), 32'd0);
        wait_idle();

        $display("[TB] reset on third handshake");
        apply_stimulus(4'd0, 5'd10, 1'b0);
        target = hs_seen + 3;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            if (hs_seen >= target) break;
        end
        check_output("third_handshake_seen", 32'(hs_seen >= target), 32'd1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1;
        apply_stimulus(4'd5, 5'd2, 1'b0);
        wait_idle();

        $display("[TB] command held during burst");
        apply_stimulus(4'd2, 5'd3, 1'b0);
        apply_stimulus(4'd9, 5'd2, 1'b1);
        wait_idle();

        $display("[TB] randomized bursts");
        ready_mode = 2;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < RAM_WORDS; i++) ram_mem[i] = 16'($urandom);
            len_r = $urandom_range(0, 16);
            apply_stimulus(4'($urandom_range(0, 15)), 5'(len_r), 1'b0);
            wait_idle();
        end
        ready_mode = 0;

        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Single-clock read-side client for the team's dual-port `ram` block. It accepts a burst command (base address and length) and walks the RAM read port at up to one word per cycle. It hides the RAM's one-cycle registered read latency and delivers the words on a valid/ready stream with full backpressure support. It sits between the `ram` read port (`clk_read` tied to `clk`) and any downstream consumer.

## Interface
- `D_WIDTH`, 16, data word width; must match the `ram` data width.
- `A_WIDTH`, 4, address width; RAM depth is 2^A_WIDTH.
- `FIFO_DEPTH`, 4, output buffer entries; minimum 3 for full throughput.
- `clk` input 1: the only clock; the `ram` `clk_read` connects to this same clock.
- `rst` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: burst command present.
- `cmd_ready` output 1: the command is accepted when both `cmd_valid` and `cmd_ready` are high at a rising edge.
- `cmd_addr` input A_WIDTH: burst base address.
- `cmd_len` input A_WIDTH+1: word count, 0..2^A_WIDTH.
- `address_read` output A_WIDTH: drives the `ram` `address_read` port.
- `data_read` input D_WIDTH: from the `ram` `data_read` port.
- `out_valid` output 1; `out_ready` input 1: output stream handshake.
- `out_data` output D_WIDTH: the word read from the RAM.
- `out_last` output 1: marks the final word of the burst.
- `busy` output 1: high when the state is not IDLE.
- `done` output 1: one-cycle pulse when the burst completes.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `cmd_ready`=1.
  - On accept with `cmd_len`>0: load the address register with `cmd_addr`, which counts as the first read issue; go to RUN, or straight to DRAIN if `cmd_len`=1.
  - On accept with `cmd_len`=0: no reads and no output words; `done` pulses in the next cycle; stay in IDLE.
- RUN:
  - `cmd_ready`=0.
  - Issue one read per cycle while the credit rule allows it.
  - Address increments modulo 2^A_WIDTH, so base 14 with length 4 reads 14, 15, 0, 1.
  - After the issue count reaches `cmd_len`, go to DRAIN.
- DRAIN:
  - `cmd_ready`=0; no new issues.
  - When the `out_last` word handshakes, `done` pulses in the next cycle and the state returns to IDLE.
- Read pipeline:
  - A read is issued at the edge that loads `address_read`.
  - The `ram` registers the word at the next edge.
  - Capture into the FIFO happens one edge after that.
  - A two-stage valid shift register tracks which `data_read` values belong to the burst. Untracked `data_read` values are ignored.
- Credit rule:
  - occupancy = FIFO entries + reads in flight (0..2).
  - A read may issue in a cycle only if occupancy − (1 if an output handshake occurs that cycle) < FIFO_DEPTH.
  - The FIFO therefore never overflows, and `out_ready` low stalls issuing with no data loss.
- `out_last` is carried in the FIFO alongside each word. It is set only on the entry for issue number `cmd_len`.
- `address_read` holds its last value when no read is issuing.
- Coherence: if the RAM write port writes the same address at the same edge the RAM samples the read, the old contents are returned. The reader does not arbitrate.

## Timing
- Reset values:
  - state IDLE, so `cmd_ready`=1 and `busy`=0.
  - `address_read`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `done`=0.
  - FIFO empty, in-flight flags clear.
- Reset mid-burst aborts immediately. Buffered words are discarded, and no `done` pulse or `out_last` is produced.
- Latency: with the accept at edge 0, `out_valid` first rises after edge 2.
- With `out_ready` held at 1, the burst streams `cmd_len` consecutive words, and `done` is high for the cycle after the last handshake.
- `out_data` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
- `done` and the command-accept edge never coincide; the next command is accepted no earlier than the cycle `done` is high.
- `busy` rises the cycle after the accept and falls together with the `done` pulse.

## Structure
- Shared package `ram_pkg`:
  - `D_WIDTH`/`A_WIDTH` defaults shared with `ram`.
  - State encoding enum: IDLE=0, RUN=1, DRAIN=2.
- Sub-module `ram_rd_fifo`: synchronous FIFO with registered output, depth `FIFO_DEPTH`, width D_WIDTH+1 (data plus last flag). It exposes a count for the credit rule.
- The top level holds the FSM, the address and issue counters, the in-flight shift register and the credit logic.

## Test plan
- Preload RAM[i]=16'hA000+i; command addr 0, len 16, `out_ready`=1 → `out_valid` rises after edge 2; data A000..A00F in 16 consecutive cycles; `out_last` only on A00F; `done` the next cycle.
- Command addr 14, len 4 → `address_read` sequence 14, 15, 0, 1; outputs A00E, A00F, A000, A001.
- len 8 with `out_ready` toggling 1,0,0,1 repeatedly → all 8 words in order, none dropped or duplicated; FIFO count never exceeds 4; `out_data` stable while stalled.
- `cmd_len`=0 → no `out_valid`; `done` pulse one cycle after accept; `cmd_ready` stays 1.
- Assert `rst` on the 3rd output handshake of a len-10 burst → all outputs at reset values; a new command addr 5, len 2 then returns A005, A006 with `out_last` on A006.
- `cmd_valid` held high during a burst → `cmd_ready`=0 and the second command is accepted in the cycle `done` is high, not before.
